// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the cache port arbiter and the
//               Cache it drives: arbiter FSM state encoding, default bus
//               widths, and the latency counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default widths, matching a Cache with size=1024 and an 8-bit out_value
    localparam int c_default_addr_width = 10;
    localparam int c_default_data_width = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Width of a down-counter that must hold values 0..read_latency
    function automatic int lat_cnt_width(input int read_latency);
        return (read_latency < 1) ? 1 : $clog2(read_latency + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin picker. A lone requester
//               wins outright; on a tie the port that was not served last
//               wins.
// Ports       : req[1:0]     - request per port (bit 0 = port 0)
//               last_served  - id of the most recently granted port
//               grant_valid  - at least one request is present
//               grant_id     - id of the winning port
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last_served;
        end else begin
            grant_id = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arbiter
// Description : Shares a single-ported Cache between instruction fetch
//               (port 0) and load/store (port 1). Arbitrates round-robin,
//               latches the winner's command, issues one read or write
//               strobe, waits READ_LATENCY cycles and returns read data.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               rX_req/write/addr/wdata  - requester command, held until ack
//               rX_ack                   - one-cycle command-accepted pulse
//               rX_rvalid/rX_rdata       - one-cycle read response, data held
//               cache_address/read/write/wdata - Cache command interface
//               cache_rdata              - Cache read data (out_value)
//               busy                     - FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_default_addr_width,
    parameter int DATA_WIDTH   = c_default_data_width,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ack,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ack,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic                  cache_read,
    output logic                  cache_write,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_read_latency
        $error("cache_port_arbiter: READ_LATENCY must be in the range 1..7");
    end

    localparam int                 c_cnt_w    = lat_cnt_width(READ_LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(READ_LATENCY - 1);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_last_served;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_id;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  w_grant_valid;
    logic                  w_grant_id;

    rr_arbiter2 u_rr_arbiter2 (
        .req         ({r1_req, r0_req}),
        .last_served (r_last_served),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Next state and strobes. Acks derive from the registered state, so a
    // request never reaches an ack combinationally.
    always_comb begin
        w_next_state = r_state;
        cache_read   = 1'b0;
        cache_write  = 1'b0;
        r0_ack       = 1'b0;
        r1_ack       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                cache_read   = ~r_write;
                cache_write  = r_write;
                r0_ack       = ~r_id;
                r1_ack       = r_id;
                w_next_state = r_write ? IDLE : WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_cnt         <= '0;
            r_id          <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_id          <= w_grant_id;
                        r_last_served <= w_grant_id;
                        r_write       <= w_grant_id ? r1_write : r0_write;
                        r_addr        <= w_grant_id ? r1_addr  : r0_addr;
                        r_wdata       <= w_grant_id ? r1_wdata : r0_wdata;
                    end
                end
                ISSUE: begin
                    if (!r_write) begin
                        r_cnt <= c_cnt_load;
                    end
                end
                WAIT: begin
                    // Counter reaches zero in the cycle cache_rdata is valid
                    if (r_cnt == '0) begin
                        if (r_id) begin
                            r_rdata1  <= cache_rdata;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= cache_rdata;
                            r_rvalid0 <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cache_address = r_addr;
    assign cache_wdata   = r_wdata;
    assign r0_rdata      = r_rdata0;
    assign r1_rdata      = r_rdata1;
    assign r0_rvalid     = r_rvalid0;
    assign r1_rvalid     = r_rvalid1;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single-ported Cache between two requesters: port 0 (instruction fetch) and port 1 (load/store).
- Performs two-way round-robin arbitration and latches the winner's command.
- Drives one read or write strobe to the cache, waits a fixed read latency, and returns read data to the winning requester.
- Sits between the core's fetch and LSU stages and the Cache instance.

Parameters:
- ADDR_WIDTH, 10, cache address width. Matches a Cache with size=1024.
- DATA_WIDTH, 8, data width. Matches the Cache 8-bit out_value.
- READ_LATENCY, 1, cycles from the cache_read strobe cycle to the cycle cache_rdata is valid. Legal range 1..7; values outside this range cause an elaboration error.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- r0_req  in  1  port 0 request.
- r0_write  in  1  port 0: 1=write, 0=read.
- r0_addr  in  ADDR_WIDTH  port 0 address.
- r0_wdata  in  DATA_WIDTH  port 0 write data.
- r0_ack  out  1  port 0 command accepted. One-cycle pulse.
- r0_rvalid  out  1  port 0 read data valid. One-cycle pulse.
- r0_rdata  out  DATA_WIDTH  port 0 read data.
- r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_rvalid, r1_rdata: same directions, widths and meanings as port 0.
- cache_address  out  ADDR_WIDTH  to Cache address.
- cache_read  out  1  to Cache read strobe.
- cache_write  out  1  to Cache write strobe.
- cache_wdata  out  DATA_WIDTH  to Cache write data.
- cache_rdata  in  DATA_WIDTH  from Cache out_value.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_served=1 (port 0 wins the first tie), latency counter=0.
  - All outputs 0, including cache_address, cache_wdata, rX_rdata.
- Requester protocol:
  - Hold req, write, addr and wdata stable until ack.
  - ack is registered, never combinational from req.
  - Dropping req before ack is a protocol violation. A command already latched still completes, and ack still pulses.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req, pick a winner. If only one req is high, that port wins. If both are high, the port != last_served wins.
  - On the winning edge: latch port id, write, addr and wdata; set last_served=winner; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (cycle T):
  - cache_address and cache_wdata come from the latch.
  - Exactly one of cache_read or cache_write is high, for exactly this one cycle.
  - rX_ack=1 for the winner only.
  - Write: next state IDLE.
  - Read: load counter=READ_LATENCY-1, next state WAIT.
- WAIT:
  - cache strobes are 0; cache_address holds the latched value.
  - When counter==0 (cycle T+READ_LATENCY): register cache_rdata into the winner's rX_rdata, go to IDLE. Otherwise decrement.
- Read response:
  - rX_rvalid=1 in cycle T+READ_LATENCY+1, for one cycle, winner only.
  - This response cycle is an IDLE cycle, so a new arbitration may occur in the same cycle.
  - rX_rdata holds its last value until the next read response for that port.
  - The non-winning port's rdata is untouched.
- Timing:
  - Request seen at edge C → ack in cycle C+1.
  - Back-to-back throughput: writes every 2 cycles, reads every READ_LATENCY+2 cycles.
- Invariants:
  - cache_read and cache_write are never both 1.
  - At most one ack and at most one rvalid per cycle.
  - busy = (state != IDLE).
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1.
- Reset mid-operation:
  - The next cycle is IDLE with no strobe.
  - A pending rvalid is suppressed.
  - last_served returns to 1.

Decomposition:
- Package cache_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT}.
  - Default ADDR_WIDTH and DATA_WIDTH constants, shared with Cache.
  - Latency counter width = $clog2(READ_LATENCY+1).
- Sub-module rr_arbiter2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_served.
  - Outputs: grant_valid, grant_id.
  - Instantiated once; the FSM and latches stay in cache_port_arbiter.

Test Plan:
- Reset, then r0 read addr=0x010, READ_LATENCY=1, cache_rdata=0x5A in cycle T+1 → r0_ack at T, cache_read high only at T, r0_rvalid=1 and r0_rdata=0x5A at T+2, busy low at T+2.
- r1 write addr=0x3FF wdata=0xC3 → cache_write=1, cache_address=0x3FF, cache_wdata=0xC3 for one cycle, r1_ack that cycle; r1_rvalid never asserts.
- Both ports request reads continuously for 6 grants → ack order 0,1,0,1,0,1; each rvalid goes to the correct port with its own data.
- READ_LATENCY=3, r0 read → rvalid at T+4; cache strobes 0 during T+1..T+3; a new r1 request during WAIT is not acked before T+5.
- rst asserted in WAIT → next cycle IDLE, busy=0, all outputs 0, no rvalid; first post-reset tie goes to port 0.
- r0 drops req one cycle after a tie is arbitrated to it → r0 still acked and access completes; r1 is served next.
